// File: rtl/cmd_frontend_pkg.sv
// Shared calculator definitions: opcode encoding, bus widths and frontend FSM states.
package cmd_frontend_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIP_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_ADD  = 2'b10,
    OP_MUL  = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } fe_state_e;

  // Zero-extend the switch value to the calculator data width.
  function automatic logic [DATA_W-1:0] push_operand(input logic [DIP_W-1:0] d);
    return {{(DATA_W-DIP_W){1'b0}}, d};
  endfunction

endpackage

// File: rtl/cmd_frontend_if.sv
// Valid/ready command channel from the button frontend to the calculator.
interface cmd_frontend_if;
  import cmd_frontend_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/cmd_frontend_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer, rising-edge press pulse.
module cmd_frontend_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  // Synchronize, debounce and register a one-cycle pulse on each stable 0->1 change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      press    <= stable & ~stable_q;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_frontend.sv
// Turns three bouncy buttons plus operand switches into single valid/ready calculator commands.
module cmd_frontend
  import cmd_frontend_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIP_W-1:0]  dip,
  input  logic              aux1,
  input  logic              aux2,
  input  logic              aux3,
  cmd_frontend_if.master    cmd,
  output logic              overflow
);

  logic [DIP_W-1:0]  dip_s1;
  logic [DIP_W-1:0]  dip_s2;
  logic              push_p;
  logic              add_p;
  logic              mul_p;

  fe_state_e         state;
  fe_state_e         state_n;
  cmd_op_e           op_q;
  cmd_op_e           op_n;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_n;
  logic              drop;
  logic              any_p;
  logic              multi_p;

  cmd_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
    .clk   (clk),
    .reset (reset),
    .btn   (aux1),
    .press (push_p)
  );

  cmd_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
    .clk   (clk),
    .reset (reset),
    .btn   (aux2),
    .press (add_p)
  );

  cmd_frontend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mul (
    .clk   (clk),
    .reset (reset),
    .btn   (aux3),
    .press (mul_p)
  );

  assign any_p   = push_p | add_p | mul_p;
  assign multi_p = (push_p & add_p) | (push_p & mul_p) | (add_p & mul_p);

  // Two-flop synchronizer for the operand switches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dip_s1 <= '0;
      dip_s2 <= '0;
    end else begin
      dip_s1 <= dip;
      dip_s2 <= dip_s1;
    end
  end

  // Next-state, command load and dropped-press detection.
  always_comb begin
    state_n = state;
    op_n    = op_q;
    data_n  = data_q;
    drop    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_p) begin
          state_n = ST_PENDING;
          drop    = multi_p;
          if (push_p) begin
            op_n   = OP_PUSH;
            data_n = push_operand(dip_s2);
          end else if (add_p) begin
            op_n   = OP_ADD;
            data_n = '0;
          end else begin
            op_n   = OP_MUL;
            data_n = '0;
          end
        end
      end
      ST_PENDING: begin
        drop = any_p;
        if (cmd.cmd_ready) begin
          state_n = ST_IDLE;
          op_n    = OP_NONE;
          data_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        op_n    = OP_NONE;
        data_n  = '0;
      end
    endcase
  end

  // State, registered command outputs and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_NONE;
      data_q   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      data_q   <= data_n;
      overflow <= overflow | drop;
    end
  end

  assign cmd.cmd_valid = (state == ST_PENDING);
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_data  = data_q;

endmodule

// File: tb/tb_cmd_frontend.sv
// Directed bench for cmd_frontend with DEBOUNCE_CYCLES=4: per-cycle vector table plus a hand sequence.
module tb_cmd_frontend;

  logic       clk;
  logic       reset;
  logic [7:0] dip;
  logic       aux1;
  logic       aux2;
  logic       aux3;
  logic       ready;
  logic       overflow;

  int unsigned checks;
  int unsigned errors;

  cmd_frontend_if bus();
  assign bus.cmd_ready = ready;

  cmd_frontend #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dip      (dip),
    .aux1     (aux1),
    .aux2     (aux2),
    .aux3     (aux3),
    .cmd      (bus),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        a1;
    logic        a2;
    logic        a3;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [1:0]  eop;
    logic [15:0] edata;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic a1, input logic a2, input logic a3,
                     input logic [7:0] d, input logic rdy, input logic ev,
                     input logic [1:0] eop, input logic [15:0] edata, input logic eovf);
    vec_t v;
    v.rst = r; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.d = d; v.rdy = rdy;
    v.ev = ev; v.eop = eop; v.edata = edata; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic idle(input int unsigned n, input logic eovf);
    for (int unsigned k = 0; k < n; k++) add(1, 0, 0, 0, 8'h00, 0, 0, 2'b00, 16'h0000, eovf);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    checks = 0;
    errors = 0;
    reset = 1'b0; dip = '0; aux1 = 0; aux2 = 0; aux3 = 0; ready = 0;

    // reset state
    add(0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 16'h0000, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 16'h0000, 0);
    idle(2, 0);

    // clean PUSH held 20 cycles, ready high: one command 7 edges after first sampling edge
    for (int k = 0; k < 20; k++)
      add(1, 1, 0, 0, 8'h2A, 1, k == 7, (k == 7) ? 2'b01 : 2'b00, (k == 7) ? 16'h002A : 16'h0000, 0);
    for (int k = 0; k < 10; k++) add(1, 0, 0, 0, 8'h2A, 1, 0, 2'b00, 16'h0000, 0);

    // bouncing ADD (2 high, 2 low) then held: no command in bounce, one ADD afterwards
    for (int k = 0; k < 12; k++) add(1, 0, (k % 4) < 2, 0, 8'h5A, 1, 0, 2'b00, 16'h0000, 0);
    for (int k = 0; k < 12; k++)
      add(1, 0, 1, 0, 8'h5A, 1, k == 7, (k == 7) ? 2'b10 : 2'b00, 16'h0000, 0);
    idle(10, 0);

    // PUSH pending with ready low, ADD pressed meanwhile: PUSH unchanged, ADD dropped, overflow
    for (int k = 0; k < 23; k++)
      add(1, 1, k >= 8, 0, (k < 8) ? 8'h55 : 8'h11, k == 20, (k >= 7) && (k <= 19),
          ((k >= 7) && (k <= 19)) ? 2'b01 : 2'b00,
          ((k >= 7) && (k <= 19)) ? 16'h0055 : 16'h0000, k >= 15);
    idle(10, 1);
    add(0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 16'h0000, 0);

    // PUSH and MUL rise together: PUSH wins, overflow set
    for (int k = 0; k < 12; k++)
      add(1, 1, 0, 1, 8'h07, 1, k == 7, (k == 7) ? 2'b01 : 2'b00, (k == 7) ? 16'h0007 : 16'h0000, k >= 7);
    idle(10, 1);
    add(0, 0, 0, 0, 8'h00, 0, 0, 2'b00, 16'h0000, 0);

    // reset pulse while PENDING, button held: fresh debounce, command 7 edges after release
    for (int k = 0; k < 25; k++)
      add(k != 9, 1, 0, 0, 8'h3C, k == 22, (k == 7) || (k == 8) || ((k >= 17) && (k <= 21)),
          ((k == 7) || (k == 8) || ((k >= 17) && (k <= 21))) ? 2'b01 : 2'b00,
          ((k == 7) || (k == 8) || ((k >= 17) && (k <= 21))) ? 16'h003C : 16'h0000, 0);
    idle(10, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; aux1 = vecs[i].a1; aux2 = vecs[i].a2; aux3 = vecs[i].a3;
      dip = vecs[i].d; ready = vecs[i].rdy;
      tick();
      check($sformatf("v%0d_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_op", i), 32'(bus.cmd_op), 32'(vecs[i].eop));
      check($sformatf("v%0d_data", i), 32'(bus.cmd_data), 32'(vecs[i].edata));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].eovf));
    end

    // MUL held pending 10 cycles while dip moves to 0xFF, released by a ready pulse
    reset = 1; aux1 = 0; aux2 = 0; aux3 = 1; dip = 8'h00; ready = 0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cmd_valid && n < 20);
    // first sampling edge is tick 1, command appears 7 edges later
    check("mul_latency", 32'(n), 32'd8);
    check("mul_op0", 32'(bus.cmd_op), 32'd3);
    check("mul_data0", 32'(bus.cmd_data), 32'd0);
    dip = 8'hFF;
    for (int k = 1; k < 10; k++) begin
      tick();
      check($sformatf("mul_hold%0d_valid", k), 32'(bus.cmd_valid), 32'd1);
      check($sformatf("mul_hold%0d_op", k), 32'(bus.cmd_op), 32'd3);
      check($sformatf("mul_hold%0d_data", k), 32'(bus.cmd_data), 32'd0);
    end
    ready = 1;
    tick();
    check("mul_done_valid", 32'(bus.cmd_valid), 32'd0);
    check("mul_done_op", 32'(bus.cmd_op), 32'd0);
    ready = 0;
    aux3 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("mul_after%0d_valid", k), 32'(bus.cmd_valid), 32'd0);
    end
    check("mul_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_frontend.md
CMD_FRONTEND -- requirements
Module: cmd_frontend

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a button level change (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port dip  input  8  operand switches, asynchronous.
REQ-005 SHALL have port aux1  input  1  PUSH button, asynchronous, active-high, bouncy.
REQ-006 SHALL have port aux2  input  1  ADD button, asynchronous, active-high, bouncy.
REQ-007 SHALL have port aux3  input  1  MUL button, asynchronous, active-high, bouncy.
REQ-008 SHALL have port cmd_valid  output  1  command pending toward the calculator.
REQ-009 SHALL have port cmd_ready  input  1  calculator accepts the command this cycle.
REQ-010 SHALL have port cmd_op  output  2  opcode: 01 PUSH, 10 ADD, 11 MUL, 00 NONE.
REQ-011 SHALL have port cmd_data  output  16  PUSH operand, dip zero-extended; 0 for ADD/MUL.
REQ-012 SHALL have port overflow  output  1  sticky flag: a press was dropped.

Function
REQ-013 SHALL pass dip, aux1, aux2, aux3 through 2-flop synchronizers before any use.
REQ-014 SHALL debounce each synchronized button: stable level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
REQ-015 SHALL generate a one-cycle press pulse per button on stable-level 0->1; release (1->0) generates nothing.
REQ-016 SHALL use a two-state FSM: IDLE (cmd_valid=0), PENDING (cmd_valid=1).
REQ-017 SHALL, in IDLE on any press pulse, load cmd_op/cmd_data and enter PENDING next cycle.
REQ-018 SHALL, for simultaneous press pulses, take priority PUSH > ADD > MUL, drop the others, and set overflow.
REQ-019 SHALL capture cmd_data from the synchronized dip in the press-pulse cycle; later dip changes do not alter a pending command.
REQ-020 SHALL hold cmd_valid, cmd_op, cmd_data stable in PENDING until a cycle with cmd_ready=1, then return to IDLE next cycle with cmd_op=00, cmd_data=0.
REQ-021 SHALL, on a press pulse while PENDING (including the handshake cycle), drop the press and set overflow; no queueing.
REQ-022 SHALL produce cmd_valid exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first clock edge sampling a clean button high (from IDLE).
REQ-023 SHALL ignore cmd_ready while IDLE.
REQ-024 SHALL accept at most one command per press; a held button yields one command.

Reset
REQ-025 SHALL, while reset=0 at a clock edge, force: cmd_valid=0, cmd_op=00, cmd_data=0, overflow=0, FSM=IDLE, synchronizers=0, stable levels=0, debounce counters=0.
REQ-026 SHALL discard a pending command on reset mid-handshake; a button held through reset release is debounced afresh and produces one command.
REQ-027 SHALL clear overflow only by reset.

Structure
REQ-028 SHALL place opcode constants (NONE, PUSH, ADD, MUL) and the 2-bit opcode width in the shared calculator package also used by the stack/calculator.
REQ-029 SHALL implement synchronizer plus debouncer plus rising-edge pulse as one sub-module, debounce, instantiated three times; counter width derived from DEBOUNCE_CYCLES.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 SHALL cover: dip=0x2A, aux1 clean high held 20 cycles, cmd_ready=1 -> cmd_valid high one cycle at edge 7, cmd_op=01, cmd_data=0x002A, exactly one command.
REQ-031 SHALL cover: aux2 toggling every 2 cycles for 12 cycles then high -> no command during bounce; one ADD (10, data 0) 7 cycles after final stable high.
REQ-032 SHALL cover: aux3 pressed, cmd_ready=0 for 10 cycles, dip changed to 0xFF -> cmd_valid, cmd_op=11, cmd_data=0 held 10 cycles; drops after ready pulse.
REQ-033 SHALL cover: PUSH pending with cmd_ready=0, then ADD pressed -> PUSH delivered unchanged, ADD lost, overflow=1.
REQ-034 SHALL cover: aux1 and aux3 rise same cycle -> one PUSH only, overflow=1.
REQ-035 SHALL cover: reset=0 for 1 cycle while PENDING -> next cycle all outputs 0, FSM IDLE; held button yields one new command 7 cycles after reset release.
